// File: rtl/xor_ann_seq.sv
// Sequenced 2-2-1 XOR network: one shared step neuron evaluates H1, H2, then Y
// from a writable Q4.4 weight table, with valid/ready handshakes on both sides.
module xor_ann_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic             cfg_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_h1,
  output logic             out_h2,
  output logic             busy,
  output logic [CNT_W-1:0] infer_cnt
);
  localparam int SW = WIDTH + 2;

  typedef enum logic [2:0] {IDLE, EV_H1, EV_H2, EV_OUT, DONE} state_t;

  state_t                   state;
  logic                     a_q, b_q;
  logic signed [WIDTH-1:0]  wt [9];

  // Triples of (w1, w2, bias): H1 = OR, H2 = AND, OUT = H1 & ~H2.
  function automatic logic signed [WIDTH-1:0] wdef(input int i);
    case (i)
      2:       return WIDTH'(-8);
      5:       return WIDTH'(-24);
      7:       return WIDTH'(-32);
      8:       return WIDTH'(-8);
      default: return WIDTH'(16);
    endcase
  endfunction

  logic cfg_ok;
  assign cfg_ok = cfg_we && (state == IDLE) && (cfg_addr <= 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) wt[i] <= wdef(i);
    end else if (cfg_ok) begin
      wt[cfg_addr] <= signed'(cfg_wdata);
    end
  end

  // Shared neuron: operands selected by the evaluation state.
  logic signed [WIDTH-1:0] w1, w2, bias;
  logic signed [SW-1:0]    sum;
  logic                    x1, x2, fire;

  always_comb begin
    x1   = 1'b0;
    x2   = 1'b0;
    w1   = wt[0];
    w2   = wt[1];
    bias = wt[2];
    case (state)
      EV_H1:  begin x1 = a_q;    x2 = b_q;    w1 = wt[0]; w2 = wt[1]; bias = wt[2]; end
      EV_H2:  begin x1 = a_q;    x2 = b_q;    w1 = wt[3]; w2 = wt[4]; bias = wt[5]; end
      EV_OUT: begin x1 = out_h1; x2 = out_h2; w1 = wt[6]; w2 = wt[7]; bias = wt[8]; end
      default: ;
    endcase
    sum  = SW'(bias) + (x1 ? SW'(w1) : '0) + (x2 ? SW'(w2) : '0);
    fire = !sum[SW-1] && (sum != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= 1'b0;
      out_h1    <= 1'b0;
      out_h2    <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      infer_cnt <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      cfg_err <= cfg_we && ((state != IDLE) || (cfg_addr > 4'd8));
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_q      <= in_a;
          b_q      <= in_b;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= EV_H1;
        end
        EV_H1: begin out_h1 <= fire; state <= EV_H2; end
        EV_H2: begin out_h2 <= fire; state <= EV_OUT; end
        EV_OUT: begin
          out_y     <= fire;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          infer_cnt <= infer_cnt + 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/xor_ann_seq.md
Name: xor_ann_seq

Overview:
- Sequenced, configurable version of the fixed-weight 2-2-1 XOR network.
- A single shared step-activation neuron datapath evaluates H1, H2, then Y over consecutive cycles.
- Weights and biases (Q4.4, scale 16) live in a writable table.
- Sits between an input stream and a result stream, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16: signed weight/bias width, Q4.4 values in 16-bit two's complement.
- CNT_W, 16: width of the inference counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_a  input  1  boolean input A.
- in_b  input  1  boolean input B.
- cfg_we  input  1  weight table write strobe.
- cfg_addr  input  4  weight table address.
- cfg_wdata  input  WIDTH  signed write data.
- cfg_err  output  1  one-cycle pulse: write rejected.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_y  output  1  network output Y.
- out_h1  output  1  hidden neuron H1.
- out_h2  output  1  hidden neuron H2.
- busy  output  1  FSM not in IDLE.
- infer_cnt  output  CNT_W  completed (handed-off) inferences.

Behaviour:
- Reset:
  - The one clock is clk; reset is rst_n, asynchronous and active-low.
  - Assertion immediately forces FSM to IDLE.
  - in_ready=1 after reset; out_valid, out_y, out_h1, out_h2, busy, cfg_err and infer_cnt are all 0.
  - Weight table returns to defaults.
  - Reset mid-inference discards the sample; no result is produced.
- Weight table: 9 entries, triples of (w1, w2, bias).
  - addr 0..2 = H1, default 16, 16, -8 (OR).
  - addr 3..5 = H2, default 16, 16, -24 (AND).
  - addr 6..8 = OUT, default 16, -32, -8.
- Config writes:
  - Write when cfg_we=1, state=IDLE and cfg_addr<=8; takes effect on the next edge.
  - cfg_we=1 with addr 9..15, or in any non-IDLE state: no write, cfg_err=1 for the following cycle.
  - A write and an input accept in the same IDLE cycle: the write lands first, and the new weight applies to that sample.
- Neuron datapath:
  - sum = bias + (x1 ? w1 : 0) + (x2 ? w2 : 0), computed in WIDTH+2 bits with sign extension; no overflow or saturation possible.
  - Output is 1 iff sum > 0 (strict); sum == 0 gives 0.
- FSM: IDLE -> EV_H1 -> EV_H2 -> EV_OUT -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a/in_b and go to EV_H1.
  - EV_H1: neuron on (A, B) with entries 0..2; register H1.
  - EV_H2: neuron on (A, B) with entries 3..5; register H2.
  - EV_OUT: neuron on (H1, H2) with entries 6..8; register Y; go to DONE.
  - DONE: out_valid=1 with out_y/out_h1/out_h2 stable. Hold until out_ready=1.
  - On the out_valid&&out_ready edge: infer_cnt+=1, wrapping at 2^CNT_W to 0; return to IDLE.
- Timing:
  - Accept on edge k gives out_valid high after edge k+3.
  - in_ready is 0 from edge k until the edge after the handoff.
  - Minimum 5 cycles per inference with out_ready held high.
  - out_h1/out_h2/out_y keep their last values in IDLE; only out_valid qualifies them.
- busy = (state != IDLE).
- in_valid while not ready is ignored; nothing is queued.

Test Plan:
- Default weights, out_ready=1, inputs (0,0), (0,1), (1,0), (1,1):
  - Y = 0, 1, 1, 0.
  - (H1,H2) = (0,0), (1,0), (1,0), (1,1).
  - out_valid exactly 3 edges after each accept.
  - infer_cnt = 4 at the end.
- Back-pressure: inputs (1,0), out_ready=0 for 6 cycles, then 1:
  - out_valid and outputs held stable all 6 cycles.
  - in_ready=0 throughout; in_valid pulses are ignored.
  - infer_cnt increments once.
- Reconfigure OUT to (w1=16, w2=16, bias=-8) in IDLE, run (1,1):
  - Y=1 (OR of hidden).
  - Writing addr 12 gives cfg_err pulse and no table change.
- Write to addr 0 during EV_H2:
  - cfg_err=1 next cycle; the in-flight result equals the default computation.
  - Later inferences still use default w1=16.
- Boundary sum==0: set H1 bias=-16, input (1,0):
  - H1 sum=0, so H1=0 and Y=0.
- Reset mid-operation: assert rst_n=0 in EV_H1 for 1 cycle:
  - Immediate out_valid=0, busy=0, infer_cnt=0, in_ready=1.
  - Weights back at defaults, verified by an (0,1) run giving Y=1.
